decode_dispatch_buffer: RTL and testbench
=========================================

// Module: decode_dispatch_buffer
// PURPOSE
//   Parametrised decode stage between fetch and the issue queue. Decodes up to DECODE_WIDTH
//   instructions per cycle with per-lane decoder instances, holds them in a registered
//   in-order buffer, and pushes the oldest min(count, iq_size_left) entries to the issue queue
//   each cycle. Leftover entries are compacted and retried, so dispatch is no longer all-or-nothing.
// PARAMETERS
//   DECODE_WIDTH  4                          lanes decoded/buffered per cycle (1..8)
//   CNT_W         $clog2(DECODE_WIDTH+1)     width of all instruction counts
// PORTS
//   clk                      in   1                     clock, rising edge
//   rst_n                    in   1                     asynchronous reset, active low
//   flush                    in   1                     discard buffered and incoming group
//   decode_require           in   DECODE_WIDTH x DECODE_REQUIRE   fetch group; count in [0].valid_number
//   issue_queue_element      out  DECODE_WIDTH x ISSUE_QUEUE_ELEMENT  buffer slots, oldest at [0]
//   issue_queue_push_number  out  CNT_W                 entries the issue queue takes this cycle
//   iq_size_left             in   CNT_W                 free issue-queue slots this cycle
//   stall_from_decode        out  1                     incoming group not accepted; fetch holds it
// BEHAVIOUR
//   - State: buf[DECODE_WIDTH] of ISSUE_QUEUE_ELEMENT, cnt[CNT_W]. Slots 0..cnt-1 are valid, oldest first.
//   - Reset (rst_n=0, async): cnt=0. Slot contents are don't-care. Outputs: push_number=0,
//     stall_from_decode=0, issue_queue_element = the contents of buf.
//   - in_cnt = min(decode_require[0].valid_number, DECODE_WIDTH). Lanes 0..in_cnt-1 are valid; others are ignored.
//   - Push (combinational): push = min(cnt, iq_size_left). issue_queue_push_number = push.
//     issue_queue_element[k] = buf[k]. The issue queue consumes slots 0..push-1 at the clock edge.
//   - rem = cnt - push. accept = (rem == 0).
//     stall_from_decode = (in_cnt != 0) && !accept && !flush.
//   - Next state, in priority order:
//     1. flush=1: cnt<=0. push_number is still driven, since the queue handles its own flush. The incoming group is dropped.
//     2. accept && in_cnt>0: buf[k] <= decoded lane k; cnt <= in_cnt. Load-through: a group arriving
//        while the old group fully drains in the same cycle is accepted with no bubble.
//     3. otherwise: buf[k] <= buf[k+push] for k<rem; cnt <= rem.
//   - Latency: decode_require to issue_queue_element is 1 cycle. Throughput is one full group per cycle
//     when iq_size_left >= cnt.
//   - Boundaries:
//     - iq_size_left=0: push=0 and the buffer holds.
//     - iq_size_left > cnt: push=cnt.
//     - cnt=0: push=0 and accept=1.
//     - valid_number > DECODE_WIDTH: clamped.
//   - Fetch must hold decode_require stable while stall_from_decode=1. Only a contiguous in-order
//     prefix is ever pushed; no reordering.
//   - The stall path is combinational from iq_size_left. Pushes never exceed cnt or iq_size_left.
// CONFIGURATION
//   DECODE_PARTIAL_PUSH_EN defined: behaviour as above (partial push plus compaction).
//   Not defined: all-or-nothing mode.
//     - push = (cnt <= iq_size_left) ? cnt : 0.
//     - Rule 3 applies only with push=0, so buf/cnt hold and no shifter is built.
//     - Everything else is unchanged.
// TESTING
//   1. Reset: rst_n=0 mid-run with cnt=3 -> cnt=0 and push_number=0 immediately (async).
//      After release, stall=0 with no input.
//   2. Full flow: valid_number=4, iq_size_left=4 every cycle -> push_number=4 each cycle from cycle 1, stall=0 throughout.
//   3. Partial (EN): buffer holds A0..A3, iq_size_left=1 -> push 1, then A1..A3 at slots 0..2 with cnt=3.
//      Next cycle iq_size_left=3 -> push 3 and new group B accepted (load-through), stall=0.
//   4. Same stimulus as 3 without EN -> push_number=0, stall=1 while iq_size_left<4.
//      When iq_size_left=4 -> push 4 and B is loaded.
//   5. Flush: cnt=2, stall=1, flush=1 -> next cycle cnt=0. The dropped group is never pushed, stall=0.
//   6. Clamp/empty: valid_number=7 with DECODE_WIDTH=4 -> cnt=4. valid_number=0 -> no load, stall=0.

Source files
------------

// File: rtl/decode_dispatch_buffer.sv
// Decode stage between fetch and the issue queue: per-lane decoders feeding an in-order dispatch buffer.
// Optional feature macro DECODE_PARTIAL_PUSH_EN enables partial push with compaction; otherwise all-or-nothing.

package decode_dispatch_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FU_ALU = 3'd0,
    FU_MUL = 3'd1,
    FU_LSU = 3'd2,
    FU_BR  = 3'd3,
    FU_ILL = 3'd4
  } fu_e;

  typedef struct packed {
    logic [3:0]  valid_number;
    logic [31:0] pc;
    logic [31:0] instr;
  } decode_require_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    fu_e         fu;
  } issue_queue_element_t;

endpackage

module dd_lane_decoder
  import decode_dispatch_pkg::*;
(
  input  logic [31:0]          pc_i,
  input  logic [31:0]          instr_i,
  output issue_queue_element_t elem_o
);

  logic [6:0] opc;
  assign opc = instr_i[6:0];

  always_comb begin
    elem_o        = '0;
    elem_o.pc     = pc_i;
    elem_o.opcode = opc;
    elem_o.funct3 = instr_i[14:12];
    elem_o.rd     = instr_i[11:7];
    elem_o.rs1    = instr_i[19:15];
    elem_o.rs2    = instr_i[24:20];
    elem_o.fu     = FU_ILL;
    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        elem_o.imm = {instr_i[31:12], 12'b0};
        elem_o.fu  = FU_ALU;
      end
      OPC_JAL: begin
        elem_o.imm = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        elem_o.fu  = FU_BR;
      end
      OPC_JALR: begin
        elem_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
        elem_o.fu  = FU_BR;
      end
      OPC_BRANCH: begin
        elem_o.imm = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        elem_o.rd  = '0;
        elem_o.fu  = FU_BR;
      end
      OPC_LOAD: begin
        elem_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
        elem_o.fu  = FU_LSU;
      end
      OPC_STORE: begin
        elem_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
        elem_o.rd  = '0;
        elem_o.fu  = FU_LSU;
      end
      OPC_OPIMM: begin
        elem_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
        elem_o.fu  = FU_ALU;
      end
      OPC_OP: begin
        // funct7[0] selects the M-extension multiply/divide unit
        elem_o.imm = '0;
        elem_o.fu  = instr_i[25] ? FU_MUL : FU_ALU;
      end
      default: ;
    endcase
  end

endmodule

module decode_dispatch_buffer
  import decode_dispatch_pkg::*;
#(
  parameter int DECODE_WIDTH = 4,
  parameter int CNT_W        = $clog2(DECODE_WIDTH + 1)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    flush,
  input  decode_require_t      [DECODE_WIDTH-1:0] decode_require,
  output issue_queue_element_t [DECODE_WIDTH-1:0] issue_queue_element,
  output logic                 [CNT_W-1:0]        issue_queue_push_number,
  input  logic                 [CNT_W-1:0]        iq_size_left,
  output logic                                    stall_from_decode
);

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [3:0] vn);
    if (int'(vn) > DECODE_WIDTH) return CNT_W'(DECODE_WIDTH);
    else                         return CNT_W'(vn);
  endfunction

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  issue_queue_element_t [DECODE_WIDTH-1:0] dec_elem;
  issue_queue_element_t [DECODE_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] in_cnt, push, rem;
  logic             accept;
  logic             unused_vn;

  for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
    dd_lane_decoder u_dec (
      .pc_i    (decode_require[g].pc),
      .instr_i (decode_require[g].instr),
      .elem_o  (dec_elem[g])
    );
  end

  // Only lane 0 carries the group count; the other lanes' count fields are spare.
  always_comb begin
    unused_vn = 1'b0;
    for (int k = 1; k < DECODE_WIDTH; k++) unused_vn = unused_vn ^ (^decode_require[k].valid_number);
  end

  assign in_cnt = clamp_cnt(decode_require[0].valid_number);

`ifdef DECODE_PARTIAL_PUSH_EN
  assign push = min_cnt(cnt_q, iq_size_left);
`else
  assign push = (cnt_q <= iq_size_left) ? cnt_q : '0;
`endif

  assign rem    = cnt_q - push;
  assign accept = (rem == '0);

  assign issue_queue_push_number = push;
  assign issue_queue_element     = buf_q;
  assign stall_from_decode       = (in_cnt != '0) && !accept && !flush;

  always_comb begin
    buf_d = buf_q;
    cnt_d = rem;
    if (flush) begin
      cnt_d = '0;
    end else if (accept && (in_cnt != '0)) begin
      // Load-through: the old group drained completely this cycle
      buf_d = dec_elem;
      cnt_d = in_cnt;
    end
`ifdef DECODE_PARTIAL_PUSH_EN
    else begin
      for (int k = 0; k < DECODE_WIDTH; k++) begin
        for (int j = 0; j < DECODE_WIDTH; j++) begin
          if (j == k + int'(push)) buf_d[k] = buf_q[j];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Slot payload is meaningful only below cnt_q, so it carries no reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_decode_dispatch_buffer.sv
// Scoreboard bench for decode_dispatch_buffer: expected pushes queued by stimulus, checked by a monitor.
module tb_decode_dispatch_buffer;
  import decode_dispatch_pkg::*;

  localparam int DW = 4;
  localparam int CW = $clog2(DW + 1);

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           flush;
  decode_require_t      [DW-1:0]  req;
  issue_queue_element_t [DW-1:0]  elem;
  logic                 [CW-1:0]  push_n;
  logic                 [CW-1:0]  iq_left;
  logic                           stall;

  decode_dispatch_buffer #(.DECODE_WIDTH(DW)) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .flush                   (flush),
    .decode_require          (req),
    .issue_queue_element     (elem),
    .issue_queue_push_number (push_n),
    .iq_size_left            (iq_left),
    .stall_from_decode       (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [31:0] base;
    bit          chk_dec;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_pc(input int g, input int k);
    return 32'(g * 256 + 4 * k);
  endfunction

  function automatic logic [31:0] mk_addi(input logic [31:0] pc);
    return {pc[11:0], 5'd0, 3'b000, pc[6:2], 7'b0010011};
  endfunction

  task automatic drive(input int vn, input int g, input int iq, input bit fl);
    for (int k = 0; k < DW; k++) begin
      req[k].pc           = mk_pc(g, k);
      req[k].instr        = mk_addi(mk_pc(g, k));
      req[k].valid_number = (k == 0) ? 4'(vn) : 4'd0;
    end
    iq_left = CW'(iq);
    flush   = fl;
  endtask

  task automatic expect_push(input int n, input int g, input int first, input bit dec);
    exp_t x;
    x.n       = n;
    x.base    = mk_pc(g, first);
    x.chk_dec = dec;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every non-zero push is matched against the oldest expected dispatch.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && push_n != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_push", 32'(push_n), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("push_number", 32'(push_n), 32'(e.n));
        for (int k = 0; k < e.n && k < DW; k++) begin
          chk("slot_pc", elem[k].pc, e.base + 32'(4 * k));
          if (e.chk_dec) begin
            chk("slot_imm", elem[k].imm, {{20{e.base[11] ^ 1'b0}}, 12'(e.base + 32'(4 * k))});
            chk("slot_rd", 32'(elem[k].rd), 32'((e.base + 32'(4 * k)) >> 2) & 32'h1f);
            chk("slot_fu", 32'(elem[k].fu), 32'(FU_ALU));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 4, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_push", 32'(push_n), 0);
    chk("reset_stall", 32'(stall), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Async reset with a partly filled buffer
    drive(3, 1, 0, 0);
    @(negedge clk); chk("t1_stall_empty", 32'(stall), 0);
    tick();
    drive(0, 0, 0, 0);
    @(negedge clk); chk("t1_hold_push", 32'(push_n), 0);
    #1; rst_n = 1'b0; iq_left = CW'(4);
    #1; chk("t1_async_push", 32'(push_n), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t1_post_stall", 32'(stall), 0);
    chk("t1_post_push", 32'(push_n), 0);
    tick();

    // Full-rate flow
    for (int i = 0; i < 4; i++) begin
      drive(4, 2 + i, 4, 0);
      expect_push(4, 2 + i, 0, 1);
      @(negedge clk);
      chk("t2_stall", 32'(stall), 0);
      if (i > 0) chk("t2_push", 32'(push_n), 4);
      tick();
    end
    drive(0, 0, 4, 0);
    @(negedge clk); chk("t2_last_push", 32'(push_n), 4);
    tick();

    // Partial vs all-or-nothing drain of group A (g=6) with group B (g=7) waiting
    drive(4, 6, 0, 0);
    @(negedge clk); chk("t3_load_stall", 32'(stall), 0);
    tick();
`ifdef DECODE_PARTIAL_PUSH_EN
    drive(4, 7, 1, 0);
    expect_push(1, 6, 0, 1);
    @(negedge clk); chk("t3_stall_iq1", 32'(stall), 1);
    tick();
    drive(4, 7, 3, 0);
    expect_push(3, 6, 1, 1);
    @(negedge clk); chk("t3_loadthru_stall", 32'(stall), 0);
    tick();
`else
    drive(4, 7, 1, 0);
    @(negedge clk);
    chk("t4_stall_iq1", 32'(stall), 1);
    chk("t4_push_iq1", 32'(push_n), 0);
    tick();
    drive(4, 7, 3, 0);
    @(negedge clk);
    chk("t4_stall_iq3", 32'(stall), 1);
    chk("t4_push_iq3", 32'(push_n), 0);
    tick();
    drive(4, 7, 4, 0);
    expect_push(4, 6, 0, 1);
    @(negedge clk); chk("t4_stall_iq4", 32'(stall), 0);
    tick();
`endif
    drive(0, 0, 4, 0);
    expect_push(4, 7, 0, 1);
    @(negedge clk); chk("t3_drain_b", 32'(push_n), 4);
    tick();

    // Flush drops both the buffered and the incoming group
    drive(2, 8, 0, 0);
    tick();
    drive(4, 9, 0, 0);
    @(negedge clk); chk("t5_stall_before", 32'(stall), 1);
    #1; flush = 1'b1;
    #1; chk("t5_stall_flush", 32'(stall), 0);
    tick();
    drive(0, 0, 4, 0);
    @(negedge clk);
    chk("t5_push_after", 32'(push_n), 0);
    chk("t5_stall_after", 32'(stall), 0);
    tick();

    // Count clamp and empty group
    drive(7, 10, 0, 0);
    @(negedge clk); chk("t6_stall", 32'(stall), 0);
    tick();
    drive(0, 0, 7, 0);
    expect_push(4, 10, 0, 1);
    @(negedge clk); chk("t6_clamp_push", 32'(push_n), 4);
    tick();
    drive(0, 0, 4, 0);
    @(negedge clk);
    chk("t6_empty_push", 32'(push_n), 0);
    chk("t6_empty_stall", 32'(stall), 0);
    tick();

    // Mixed instruction formats through the lane decoders
    drive(4, 11, 0, 0);
    req[0].instr = {20'h12345, 5'd5, 7'b0110111};
    req[1].instr = {7'h7f, 5'd7, 5'd2, 3'b010, 5'h18, 7'b0100011};
    req[2].instr = {1'b0, 6'd0, 5'd2, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011};
    req[3].instr = {7'b0000001, 5'd5, 5'd4, 3'b000, 5'd3, 7'b0110011};
    tick();
    @(negedge clk);
    chk("dec_lui_imm", elem[0].imm, 32'h12345000);
    chk("dec_lui_rd", 32'(elem[0].rd), 5);
    chk("dec_sw_imm", elem[1].imm, 32'hfffffff8);
    chk("dec_sw_rs2", 32'(elem[1].rs2), 7);
    chk("dec_sw_fu", 32'(elem[1].fu), 32'(FU_LSU));
    chk("dec_beq_imm", elem[2].imm, 32'd16);
    chk("dec_beq_fu", 32'(elem[2].fu), 32'(FU_BR));
    chk("dec_mul_fu", 32'(elem[3].fu), 32'(FU_MUL));
    chk("dec_mul_rd", 32'(elem[3].rd), 3);
    drive(0, 0, 4, 0);
    expect_push(4, 11, 0, 0);
    tick();
    repeat (3) tick();

    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
